// File: rtl/axi_slv_pkg.sv
// Shared state encodings and constants for the AXI3 SRAM slave.
// The LFSR constants are only used when AXI_SLV_STALL_EN is defined.
package axi_slv_pkg;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_WAIT = 2'd2,
    R_DATA = 2'd3
  } r_state_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_t;

  localparam logic [1:0]  RESP_OKAY = 2'b00;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 expressed as a mask over bits [15:0].
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/axi_slv_lfsr.sv
// 16-bit Fibonacci LFSR providing pseudo-random back-pressure.
// Instantiated by axi_sram_slave only when AXI_SLV_STALL_EN is defined.
module axi_slv_lfsr
  import axi_slv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] lfsr
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr <= LFSR_SEED;
    else       lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
  end

endmodule

// File: rtl/axi_sram_slave.sv
// AXI3 slave terminating one read and one write INCR burst onto a single-port SRAM.
// Define AXI_SLV_STALL_EN to add LFSR-driven back-pressure on ar/aw/w and read data.
module axi_sram_slave
  import axi_slv_pkg::*;
#(
  parameter int unsigned RAM_AW = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        arid,
  input  logic [31:0]       araddr,
  input  logic [7:0]        arlen,
  input  logic              arvalid,
  output logic              arready,
  output logic [3:0]        rid,
  output logic [31:0]       rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready,
  input  logic [3:0]        awid,
  input  logic [31:0]       awaddr,
  input  logic [7:0]        awlen,
  input  logic              awvalid,
  output logic              awready,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  input  logic              wlast,
  input  logic              wvalid,
  output logic              wready,
  output logic [3:0]        bid,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  output logic              ram_en,
  output logic [3:0]        ram_wen,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  r_state_t    r_state, r_next;
  w_state_t    w_state, w_next;
  logic [31:0] r_addr, w_addr;
  logic [3:0]  r_len, r_beat;
  logic        r_fresh;
  logic        stall_a, stall_r;
  logic        ar_fire, aw_fire, w_fire, r_fire;

`ifdef AXI_SLV_STALL_EN
  logic [15:0] lfsr;

  axi_slv_lfsr u_lfsr (
    .clk   (clk),
    .reset (reset),
    .lfsr  (lfsr)
  );

  assign stall_a = lfsr[0];
  assign stall_r = lfsr[1];
`else
  assign stall_a = 1'b0;
  assign stall_r = 1'b0;
`endif

  assign rresp   = RESP_OKAY;
  assign bresp   = RESP_OKAY;
  assign ar_fire = arvalid & arready;
  assign aw_fire = awvalid & awready;
  assign w_fire  = wvalid & wready;
  assign r_fire  = rvalid & rready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= R_IDLE;
      w_state <= W_IDLE;
    end else begin
      r_state <= r_next;
      w_state <= w_next;
    end
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE: if (ar_fire) r_next = R_ADDR;
      R_ADDR: r_next = R_WAIT;
      R_WAIT: if (!stall_r) r_next = R_DATA;
      R_DATA: if (rready) r_next = (r_beat == r_len) ? R_IDLE : R_ADDR;
      default: r_next = R_IDLE;
    endcase
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE: if (aw_fire) w_next = W_DATA;
      W_DATA: if (w_fire && wlast) w_next = W_RESP;
      W_RESP: if (bready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  // Read issue owns the SRAM port; the write beat is held off through wready.
  always_comb begin
    arready   = (r_state == R_IDLE) & ~reset & ~stall_a;
    awready   = (w_state == W_IDLE) & ~reset & ~stall_a;
    wready    = (w_state == W_DATA) & (r_state != R_ADDR) & ~stall_a;
    rvalid    = (r_state == R_DATA);
    rlast     = (r_state == R_DATA) & (r_beat == r_len);
    bvalid    = (w_state == W_RESP);
    ram_en    = 1'b0;
    ram_wen   = '0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (r_state == R_ADDR) begin
      ram_en   = 1'b1;
      ram_addr = r_addr[RAM_AW+1:2];
    end else if (wvalid && wready) begin
      ram_en    = 1'b1;
      ram_wen   = wstrb;
      ram_addr  = w_addr[RAM_AW+1:2];
      ram_wdata = wdata;
    end
  end

  // r_fresh marks the single R_WAIT cycle in which ram_rdata belongs to this beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rid     <= '0;
      rdata   <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_beat  <= '0;
      r_fresh <= 1'b0;
      bid     <= '0;
      w_addr  <= '0;
    end else begin
      r_fresh <= (r_state == R_ADDR);
      if (ar_fire) begin
        rid    <= arid;
        r_addr <= araddr;
        r_len  <= arlen[3:0];
        r_beat <= '0;
      end
      if (r_state == R_WAIT && r_fresh) rdata <= ram_rdata;
      if (r_fire && !rlast) begin
        r_beat <= r_beat + 4'd1;
        r_addr <= r_addr + 32'd4;
      end
      if (aw_fire) begin
        bid    <= awid;
        w_addr <= awaddr;
      end
      if (w_fire) w_addr <= w_addr + 32'd4;
    end
  end

  logic unused_bits;
`ifdef AXI_SLV_STALL_EN
  assign unused_bits = ^{awlen, arlen[7:4], r_addr[1:0], r_addr[31:RAM_AW+2],
                         w_addr[1:0], w_addr[31:RAM_AW+2], lfsr[15:2]};
`else
  assign unused_bits = ^{awlen, arlen[7:4], r_addr[1:0], r_addr[31:RAM_AW+2],
                         w_addr[1:0], w_addr[31:RAM_AW+2]};
`endif

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed self-checking bench for axi_sram_slave in its default build,
// with a behavioural read-first synchronous SRAM.
module tb_axi_sram_slave;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  arid, rid, awid, bid;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic [7:0]  arlen, awlen;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [1:0]  rresp, bresp;
  logic [3:0]  wstrb, ram_wen;
  logic        ram_en;
  logic [15:0] ram_addr;
  logic [31:0] ram_wdata, ram_rdata;

  logic [31:0] mem [0:65535];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi_sram_slave #(.RAM_AW(16)) dut (
    .clk(clk), .reset(reset),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .ram_en(ram_en), .ram_wen(ram_wen), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always @(posedge clk) begin
    if (ram_en) begin
      for (int i = 0; i < 4; i++)
        if (ram_wen[i]) mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
      ram_rdata <= mem[ram_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic ar_issue(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
    int n = 0;
    arid = id; araddr = addr; arlen = len; arvalid = 1'b1;
    #1;
    while (!arready && n < 20) begin @(posedge clk); #1; n++; end
    check("ar_accept", arready, 1);
    @(posedge clk); #1;
    arvalid = 1'b0;
  endtask

  task automatic aw_issue(input logic [3:0] id, input logic [31:0] addr);
    int n = 0;
    awid = id; awaddr = addr; awlen = 8'd0; awvalid = 1'b1;
    #1;
    while (!awready && n < 20) begin @(posedge clk); #1; n++; end
    check("aw_accept", awready, 1);
    @(posedge clk); #1;
    awvalid = 1'b0;
  endtask

  task automatic rd_beat(input string tag, input logic [31:0] exp_d, input logic exp_last,
                         input int stall);
    int n = 0;
    while (!rvalid && n < 20) begin @(posedge clk); #1; n++; end
    check({tag, "_valid"}, rvalid, 1);
    check({tag, "_data"}, rdata, exp_d);
    check({tag, "_last"}, rlast, exp_last);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, rvalid, 1);
      check({tag, "_hold_data"}, rdata, exp_d);
    end
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1;
    arid = '0; araddr = '0; arlen = '0; arvalid = 1'b0; rready = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    mem[16'h0001] <= 32'hDEADBEEF;
    for (int i = 0; i < 4; i++) mem[16'h0040 + i] <= 32'hA0B0_C000 + i;
    mem[16'h0080] <= 32'hAAAAAAAA;
    mem[16'h0090] <= 32'h55667788;
    mem[16'h00A0] <= 32'h0;

    #7;
    check("rst_arready", arready, 0);
    check("rst_awready", awready, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_rlast", rlast, 0);
    check("rst_ram_en", ram_en, 0);
    check("rst_ram_wen", ram_wen, 0);
    check("rst_rdata", rdata, 0);
    check("rst_rid", rid, 0);
    check("rst_bid", bid, 0);
    @(negedge clk); reset = 1'b0;
    #1 check("rel_arready", arready, 1);

    // Single-beat read: rvalid two edges after the R_ADDR edge.
    ar_issue(4'h5, 32'h1FC0_0004, 8'd0);
    check("t1_lat_addr", rvalid, 0);
    check("t1_ram_addr", ram_addr, 16'h0001);
    @(posedge clk); #1;
    check("t1_lat_wait", rvalid, 0);
    @(posedge clk); #1;
    check("t1_rvalid", rvalid, 1);
    check("t1_rdata", rdata, 32'hDEADBEEF);
    check("t1_rlast", rlast, 1);
    check("t1_rresp", rresp, 0);
    check("t1_rid", rid, 4'h5);
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    check("t1_done", rvalid, 0);

    // 4-beat read with back-pressure on beat 2.
    ar_issue(4'h9, 32'h0000_0100, 8'd3);
    for (int b = 0; b < 4; b++)
      rd_beat($sformatf("t2_b%0d", b), 32'hA0B0_C000 + b, b == 3, (b == 1) ? 2 : 0);
    check("t2_rid", rid, 4'h9);

    // Partial-strobe write.
    aw_issue(4'h3, 32'h0000_0200);
    wvalid = 1'b1; wdata = 32'h12345678; wstrb = 4'b0011; wlast = 1'b1;
    #1;
    check("t3_wready", wready, 1);
    check("t3_ram_en", ram_en, 1);
    check("t3_ram_wen", ram_wen, 4'b0011);
    check("t3_ram_addr", ram_addr, 16'h0080);
    @(posedge clk); #1;
    wvalid = 1'b0;
    check("t3_bvalid", bvalid, 1);
    check("t3_bid", bid, 4'h3);
    check("t3_bresp", bresp, 0);
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    check("t3_bdone", bvalid, 0);
    check("t3_mem", mem[16'h0080], 32'hAAAA5678);

    // Simultaneous ar and aw; the read issue stalls the write beat.
    arid = 4'hA; araddr = 32'h240; arlen = 8'd0; arvalid = 1'b1;
    awid = 4'hB; awaddr = 32'h280; awlen = 8'd0; awvalid = 1'b1;
    wvalid = 1'b1; wdata = 32'hCAFEF00D; wstrb = 4'hF; wlast = 1'b1;
    #1;
    check("t4_arready", arready, 1);
    check("t4_awready", awready, 1);
    check("t4_wready_idle", wready, 0);
    @(posedge clk); #1;
    arvalid = 1'b0; awvalid = 1'b0;
    check("t4_wready_raddr", wready, 0);
    check("t4_ram_en_rd", ram_en, 1);
    check("t4_ram_wen_rd", ram_wen, 0);
    check("t4_ram_addr_rd", ram_addr, 16'h0090);
    @(posedge clk); #1;
    check("t4_wready_wait", wready, 1);
    check("t4_ram_wen_wr", ram_wen, 4'hF);
    check("t4_ram_addr_wr", ram_addr, 16'h00A0);
    @(posedge clk); #1;
    wvalid = 1'b0;
    check("t4_rvalid", rvalid, 1);
    check("t4_rdata", rdata, 32'h55667788);
    check("t4_rid", rid, 4'hA);
    check("t4_bvalid", bvalid, 1);
    check("t4_bid", bid, 4'hB);
    rready = 1'b1; bready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0; bready = 1'b0;
    check("t4_rdone", rvalid, 0);
    check("t4_bdone", bvalid, 0);
    check("t4_mem", mem[16'h00A0], 32'hCAFEF00D);

    // Reset during beat 2 of a 4-beat read, then a fresh read.
    ar_issue(4'h2, 32'h0000_0100, 8'd3);
    rd_beat("t5_b0", 32'hA0B0_C000, 1'b0, 0);
    n = 0;
    while (!rvalid && n < 20) begin @(posedge clk); #1; n++; end
    check("t5_b1_valid", rvalid, 1);
    #2 reset = 1'b1;
    #1;
    check("t5_rst_rvalid", rvalid, 0);
    check("t5_rst_arready", arready, 0);
    check("t5_rst_ram_en", ram_en, 0);
    @(negedge clk); reset = 1'b0;
    #1 check("t5_rel_arready", arready, 1);
    ar_issue(4'h6, 32'h0000_0104, 8'd0);
    rd_beat("t5_fresh", 32'hA0B0_C001, 1'b1, 0);
    check("t5_fresh_rid", rid, 4'h6);
    check("t5_idle", rvalid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
